// File: rtl/tm1637_pkg.sv
// Shared constants and FSM state encoding for the TM1637 frame sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tm1637_pkg;

  // TM1637 command bytes
  localparam logic [7:0] CMD_DATA_AUTO = 8'h40;  // data write, auto-increment address
  localparam logic [7:0] CMD_ADDR0     = 8'hC0;  // set address to digit 0
  localparam logic [7:0] CMD_CTRL_BASE = 8'h80;  // display control, OR in enable and brightness

  // Segment patterns (gfedcba, bit 7 reserved for the colon)
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_ERR   = 8'h79;      // 'E' for non-decimal codes

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_DATA,
    S_CMD_ADDR,
    S_DIG,
    S_CMD_CTRL,
    S_DONE
  } state_t;

endpackage

// File: rtl/tm1637_frame_seq_dec_to_seg.sv
// Decimal to seven-segment encoder (gfedcba), codes 10..15 shown as 'E'.
// Latency: combinational.
// Backpressure: not applicable.
module dec_to_seg
  import tm1637_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Lookup of the segment pattern for one BCD digit
  always_comb begin
    o_seg = SEG_ERR[6:0];
    case (i_bcd)
      4'd0: o_seg = 7'h3F;
      4'd1: o_seg = 7'h06;
      4'd2: o_seg = 7'h5B;
      4'd3: o_seg = 7'h4F;
      4'd4: o_seg = 7'h66;
      4'd5: o_seg = 7'h6D;
      4'd6: o_seg = 7'h7D;
      4'd7: o_seg = 7'h07;
      4'd8: o_seg = 7'h7F;
      4'd9: o_seg = 7'h67;
      default: o_seg = SEG_ERR[6:0];
    endcase
  end

endmodule

// File: rtl/tm1637_frame_seq.sv
// TM1637 frame sequencer: captures a display value and emits the full command byte stream.
// Latency: first byte valid one cycle after update; one byte per cycle when byte_ready is held high.
// Backpressure: byte outputs hold while byte_valid && !byte_ready; TM1637_LEADING_BLANK_EN blanks leading zeros.
module tm1637_frame_seq
  import tm1637_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  update,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic                  colon,
  input  logic [2:0]            brightness,
  input  logic                  display_on,
  output logic                  busy,
  output logic [7:0]            byte_data,
  output logic                  byte_first,
  output logic                  byte_last,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  done
);

  localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

  state_t              r_state, w_next_state;
  logic [2:0]          r_idx, w_idx_next;
  logic                r_pending, w_pending_next;
  logic [4*DIGITS-1:0] r_digits;
  logic                r_colon, r_on;
  logic [2:0]          r_bright;
  logic                r_busy, r_valid, r_first, r_last, r_done;
  logic [7:0]          r_data;
  logic                w_busy, w_valid, w_first, w_last, w_done, w_capture;
  logic [7:0]          w_data;
  logic                w_xfer;
  logic [2:0]          w_sel_idx;
  logic [3:0]          w_sel_nib;
  logic [6:0]          w_seg_raw;
  logic                w_blank;
  logic [7:0]          w_seg_byte;
  logic [7:0]          w_ctrl_byte;

  assign w_xfer = r_valid & byte_ready;

  // The digit being loaded next: digit 0 when leaving the address byte, else the following digit
  assign w_sel_idx = (r_state == S_CMD_ADDR) ? 3'd0 : r_idx + 3'd1;

`ifdef TM1637_LEADING_BLANK_EN
  logic w_lead_zero;
  // Pick the selected captured digit and note whether it and every digit left of it are zero
  always_comb begin
    w_sel_nib   = 4'd0;
    w_lead_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (3'(k) == w_sel_idx) w_sel_nib = r_digits[4*k +: 4];
      if ((3'(k) <= w_sel_idx) && (r_digits[4*k +: 4] != 4'd0)) w_lead_zero = 1'b0;
    end
  end
  assign w_blank = w_lead_zero && (w_sel_idx != LAST_IDX);
`else
  // Pick the selected captured digit for the shared encoder
  always_comb begin
    w_sel_nib = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (3'(k) == w_sel_idx) w_sel_nib = r_digits[4*k +: 4];
    end
  end
  assign w_blank = 1'b0;
`endif

  dec_to_seg u_dec_to_seg (
    .i_bcd (w_sel_nib),
    .o_seg (w_seg_raw)
  );

  // Colon rides on bit 7 of digit 1 whether or not that digit is blanked
  assign w_seg_byte  = {r_colon && (w_sel_idx == 3'd1), w_blank ? SEG_BLANK[6:0] : w_seg_raw};
  assign w_ctrl_byte = CMD_CTRL_BASE | {4'b0000, r_on, r_bright};

  // Next-state and next-output logic; byte outputs only change on a transfer or frame start
  always_comb begin
    w_next_state   = r_state;
    w_idx_next     = r_idx;
    w_data         = r_data;
    w_first        = r_first;
    w_last         = r_last;
    w_valid        = r_valid;
    w_done         = 1'b0;
    w_capture      = 1'b0;
    w_pending_next = r_pending;
    if (update && (r_state != S_IDLE)) w_pending_next = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (update) begin
          w_capture    = 1'b1;
          w_next_state = S_CMD_DATA;
          w_valid      = 1'b1;
          w_data       = CMD_DATA_AUTO;
          w_first      = 1'b1;
          w_last       = 1'b1;
        end
      end
      S_CMD_DATA: begin
        if (w_xfer) begin
          w_next_state = S_CMD_ADDR;
          w_data       = CMD_ADDR0;
          w_first      = 1'b1;
          w_last       = 1'b0;
        end
      end
      S_CMD_ADDR: begin
        if (w_xfer) begin
          w_next_state = S_DIG;
          w_idx_next   = 3'd0;
          w_data       = w_seg_byte;
          w_first      = 1'b0;
          w_last       = (LAST_IDX == 3'd0);
        end
      end
      S_DIG: begin
        if (w_xfer) begin
          if (r_idx == LAST_IDX) begin
            w_next_state = S_CMD_CTRL;
            w_data       = w_ctrl_byte;
            w_first      = 1'b1;
            w_last       = 1'b1;
          end else begin
            w_idx_next = w_sel_idx;
            w_data     = w_seg_byte;
            w_first    = 1'b0;
            w_last     = (w_sel_idx == LAST_IDX);
          end
        end
      end
      S_CMD_CTRL: begin
        if (w_xfer) begin
          w_next_state = S_DONE;
          w_valid      = 1'b0;
          w_data       = 8'h00;
          w_first      = 1'b0;
          w_last       = 1'b0;
          w_done       = 1'b1;
        end
      end
      S_DONE: begin
        // A request seen during the frame or in this cycle restarts straight away
        if (r_pending || update) begin
          w_pending_next = 1'b0;
          w_capture      = 1'b1;
          w_next_state   = S_CMD_DATA;
          w_valid        = 1'b1;
          w_data         = CMD_DATA_AUTO;
          w_first        = 1'b1;
          w_last         = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    w_busy = (w_next_state != S_IDLE);
  end

  // State, output and capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 3'd0;
      r_pending <= 1'b0;
      r_digits  <= '0;
      r_colon   <= 1'b0;
      r_on      <= 1'b0;
      r_bright  <= 3'd0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_state   <= w_next_state;
      r_idx     <= w_idx_next;
      r_pending <= w_pending_next;
      r_busy    <= w_busy;
      r_valid   <= w_valid;
      r_first   <= w_first;
      r_last    <= w_last;
      r_done    <= w_done;
      r_data    <= w_data;
      if (w_capture) begin
        r_digits <= digits;
        r_colon  <= colon;
        r_on     <= display_on;
        r_bright <= brightness;
      end
    end
  end

  assign busy       = r_busy;
  assign byte_data  = r_data;
  assign byte_first = r_first;
  assign byte_last  = r_last;
  assign byte_valid = r_valid;
  assign done       = r_done;

endmodule
